output_spike_classifier: RTL
============================

Name: output_spike_classifier

Overview:
- Sits directly downstream of the network's output port. Consumes the one-hot-indexed output spike stream (packet_out / packet_out_valid) and accumulates per-class spike counts over a frame of TICKS_PER_FRAME ticks.
- At frame end it runs a sequential argmax and presents the winning class over a valid/ready handshake to the host-side consumer.
- Clears its counts and rearms for the next frame once the result is accepted.

Parameters:
- NUM_OUTPUTS, 10, number of output classes (must be >= 2).
- TICKS_PER_FRAME, 16, ticks per classification frame (must be >= 1).
- COUNT_WIDTH, 8, width of each per-class saturating spike counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  single-cycle tick pulse, same tick as the network
- packet_in  input  $clog2(NUM_OUTPUTS)  output-class index of a spike
- packet_in_valid  input  1  packet_in qualifier
- class_out  output  $clog2(NUM_OUTPUTS)  winning class index
- max_count  output  COUNT_WIDTH  spike count of winning class
- class_valid  output  1  result valid
- class_ready  input  1  consumer accepts result
- busy  output  1  high in SCAN or RESULT
- frame_error  output  1  sticky error flag

Behaviour:
- Reset (async, rst_n low):
  - state=ACCUM, tick_cnt=0, all counters=0.
  - class_out=0, max_count=0, class_valid=0, busy=0, frame_error=0.
  - Applies immediately mid-frame or mid-handshake; any pending result is discarded.
- ACCUM:
  - packet_in_valid with packet_in < NUM_OUTPUTS increments counter[packet_in], saturating at 2^COUNT_WIDTH-1 with no wrap.
  - packet_in >= NUM_OUTPUTS: ignored and frame_error set.
  - tick with tick_cnt < TICKS_PER_FRAME-1: tick_cnt++.
  - tick with tick_cnt == TICKS_PER_FRAME-1: tick_cnt<=0 and go to SCAN next cycle.
  - A spike in the same cycle as the frame-ending tick is counted in the current frame.
- SCAN:
  - Lasts exactly NUM_OUTPUTS cycles. scan_idx runs 0..NUM_OUTPUTS-1, one compare per cycle.
  - Best index/count registers are initialised from counter[0] in the first SCAN cycle.
  - Replace only on strictly greater, so ties go to the lowest index. All-zero counts give class 0, max_count 0.
  - After the last index: go to RESULT and load class_out/max_count.
- RESULT:
  - class_valid=1. class_out and max_count are held stable while class_valid && !class_ready.
  - On class_valid && class_ready: class_valid<=0, all counters cleared in that same cycle, go to ACCUM.
- Latency: frame-ending tick sampled at cycle T → class_valid high at cycle T+NUM_OUTPUTS+1. Earliest re-accumulation starts the cycle after the handshake.
- Spikes or ticks arriving in SCAN or RESULT are dropped, set frame_error, and do not advance tick_cnt.
- frame_error is cleared only by reset.
- busy = (state != ACCUM).

Optional Feature:
- Macro CLASSIFIER_COUNT_READOUT_EN.
- Defined:
  - Adds input count_rd_addr ($clog2(NUM_OUTPUTS)) and output count_rd_data (COUNT_WIDTH).
  - count_rd_data is registered: counter[count_rd_addr] one cycle after the address is applied.
  - Reads are valid in any state. Data reflects counts before the RESULT-handshake clear.
  - Out-of-range address returns 0.
- Undefined: these ports and the read mux are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding (ACCUM, SCAN, RESULT) and a function returning the saturating increment of a COUNT_WIDTH value.
- One sub-module: spike_counter_bank. Holds NUM_OUTPUTS saturating counters with increment port, synchronous clear, scan read port and optional readout port.
- The FSM, tick counter and argmax stay in the top.

Test Plan:
- Basic frame: NUM_OUTPUTS=10, TICKS_PER_FRAME=4. Spikes: class 3 ×5, class 7 ×2, then 4 ticks → class_valid at frame tick +11 with class_out=3, max_count=5. class_ready=1 → counters read 0.
- Tie and empty: classes 2 and 6 each ×4 → class_out=2. Next frame with no spikes → class_out=0, max_count=0.
- Saturation: 300 spikes to class 1 with COUNT_WIDTH=8 → max_count=255, class_out=1.
- Backpressure: class_ready held 0 for 20 cycles → class_valid stays 1 with stable outputs. Spikes and a tick injected meanwhile → frame_error=1 and the next frame's counts are unaffected.
- Boundary same-cycle: spike to class 9 coincident with the frame-ending tick → counted, class_out=9. Out-of-range index 12 → ignored, frame_error=1.
- Reset mid-SCAN: rst_n low during cycle 3 of SCAN → all outputs return to reset values immediately. A following clean frame classifies correctly.

Source files
------------

// File: rtl/output_spike_classifier_pkg.sv
// Shared types and helpers for the output spike classifier.
// Optional count readout enabled with CLASSIFIER_COUNT_READOUT_EN.
package output_spike_classifier_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/output_spike_classifier_counter_bank.sv
// Per-class saturating spike counters with scan and readout ports.
// Readout port present only with CLASSIFIER_COUNT_READOUT_EN.
module spike_counter_bank
  import output_spike_classifier_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10,
  parameter int COUNT_WIDTH = 8,
  parameter int IW = $clog2(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc_en,
  input  logic [IW-1:0]          inc_idx,
  input  logic                   clr,
  input  logic [IW-1:0]          scan_idx,
  output logic [COUNT_WIDTH-1:0] scan_data
`ifdef CLASSIFIER_COUNT_READOUT_EN
  ,
  input  logic [IW-1:0]          rd_addr,
  output logic [COUNT_WIDTH-1:0] rd_data
`endif
);

  localparam logic [31:0] MAXV =
    32'((64'd1 << COUNT_WIDTH) - 64'd1);

  logic [COUNT_WIDTH-1:0] cnt_q [NUM_OUTPUTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUTPUTS; i++)
        cnt_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_OUTPUTS; i++)
        cnt_q[i] <= '0;
    end else if (inc_en) begin
      for (int i = 0; i < NUM_OUTPUTS; i++)
        if (inc_idx == IW'(i))
          cnt_q[i] <= COUNT_WIDTH'(
            sat_inc(32'(cnt_q[i]), MAXV));
    end
  end

  always_comb begin
    scan_data = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      if (scan_idx == IW'(i))
        scan_data = cnt_q[i];
  end

`ifdef CLASSIFIER_COUNT_READOUT_EN
  logic [COUNT_WIDTH-1:0] rd_mux;

  // Unmatched (out-of-range) addresses fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      if (rd_addr == IW'(i))
        rd_mux = cnt_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_mux;
  end
`endif

endmodule

// File: rtl/output_spike_classifier.sv
// Frame-based spike counter with sequential argmax and result handshake.
// Optional count readout enabled with CLASSIFIER_COUNT_READOUT_EN.
module output_spike_classifier
  import output_spike_classifier_pkg::*;
#(
  parameter int NUM_OUTPUTS     = 10,
  parameter int TICKS_PER_FRAME = 16,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick,
  input  logic [$clog2(NUM_OUTPUTS)-1:0] packet_in,
  input  logic                           packet_in_valid,
  output logic [$clog2(NUM_OUTPUTS)-1:0] class_out,
  output logic [COUNT_WIDTH-1:0]         max_count,
  output logic                           class_valid,
  input  logic                           class_ready,
`ifdef CLASSIFIER_COUNT_READOUT_EN
  input  logic [$clog2(NUM_OUTPUTS)-1:0] count_rd_addr,
  output logic [COUNT_WIDTH-1:0]         count_rd_data,
`endif
  output logic                           busy,
  output logic                           frame_error
);

  localparam int IW = $clog2(NUM_OUTPUTS);
  localparam int TW =
    (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  state_t state_q, state_d;

  logic [TW-1:0]          tick_cnt_q;
  logic [IW-1:0]          scan_idx_q;
  logic [IW-1:0]          best_idx_q;
  logic [COUNT_WIDTH-1:0] best_cnt_q;
  logic [COUNT_WIDTH-1:0] scan_data;
  logic [IW-1:0]          cand_idx;
  logic [COUNT_WIDTH-1:0] cand_cnt;
  logic accum, in_range, frame_end;
  logic scan_last, take, hs, bad_in;

  assign accum     = (state_q == ACCUM);
  assign in_range  = 32'(packet_in) < 32'(NUM_OUTPUTS);
  assign frame_end = accum && tick &&
    (tick_cnt_q == TW'(TICKS_PER_FRAME - 1));
  assign scan_last = (state_q == SCAN) &&
    (scan_idx_q == IW'(NUM_OUTPUTS - 1));
  assign hs        = class_valid && class_ready;
  assign busy      = !accum;
  assign bad_in    = accum ?
    (packet_in_valid && !in_range) :
    (packet_in_valid || tick);

  // Strictly-greater replace keeps ties on the lowest index
  assign take     = (scan_idx_q == '0) ||
                    (scan_data > best_cnt_q);
  assign cand_idx = take ? scan_idx_q : best_idx_q;
  assign cand_cnt = take ? scan_data  : best_cnt_q;

  spike_counter_bank #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .COUNT_WIDTH (COUNT_WIDTH),
    .IW          (IW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (accum && packet_in_valid && in_range),
    .inc_idx   (packet_in),
    .clr       (hs),
    .scan_idx  (scan_idx_q),
    .scan_data (scan_data)
`ifdef CLASSIFIER_COUNT_READOUT_EN
    ,
    .rd_addr   (count_rd_addr),
    .rd_data   (count_rd_data)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == ACCUM:  if (frame_end) state_d = SCAN;
      state_q == SCAN:   if (scan_last) state_d = RESULT;
      state_q == RESULT: if (hs)        state_d = ACCUM;
      default:                          state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      class_out   <= '0;
      max_count   <= '0;
      class_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (frame_end)
        tick_cnt_q <= '0;
      else if (accum && tick)
        tick_cnt_q <= tick_cnt_q + 1'b1;
      if (state_q == SCAN) begin
        scan_idx_q <= scan_last ? '0 : scan_idx_q + 1'b1;
        best_idx_q <= cand_idx;
        best_cnt_q <= cand_cnt;
      end
      if (scan_last) begin
        class_out   <= cand_idx;
        max_count   <= cand_cnt;
        class_valid <= 1'b1;
      end else if (hs) begin
        class_valid <= 1'b0;
      end
      if (bad_in)
        frame_error <= 1'b1;
    end
  end

endmodule
